cache_refill_ctrl: RTL
======================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8: 32-bit words per cache line; power of two, at least 2.
REQ-002 SHALL have parameter SEL_WIDTH, default 3: cache entry index width; matches the tag arbiter's entry select.
REQ-003 SHALL derive WIDX = $clog2(LINE_WORDS) and OFS = WIDX+2, where OFS is the line byte-offset width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 line_miss  in  1  refill request from the tag arbiter.
REQ-007 replace_dirty  in  1  victim line dirty; write it back first.
REQ-008 force_sync  in  1  write back the selected dirty entry without refill.
REQ-009 miss_addr  in  32  missing access address.
REQ-010 victim_pa  in  32  writeback base address of the victim line.
REQ-011 entry_replace_sel  in  SEL_WIDTH  victim entry.
REQ-012 refill_pa  out  32  line-aligned refill address, valid with line_refill.
REQ-013 line_refill  out  1  one-cycle pulse: line data written, tag may update.
REQ-014 writeback_complete  out  1  one-cycle pulse: victim written back, dirty may clear.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 cache_addr  out  SEL_WIDTH+WIDX  {entry, word index}.
REQ-017 cache_we / cache_wdata / cache_rdata  out 1 / out 32 / in 32  cache data port; read data valid one cycle after address.
REQ-018 bus_req / bus_we / bus_addr / bus_wdata  out 1 / 1 / 32 / 32  word bus request.
REQ-019 bus_rdata / bus_ack  in 32 / in 1  bus response.

Function
REQ-020 SHALL implement states IDLE, WB_RD, WB_LD, WB_BUS, WB_DONE, RF_BUS, RF_DONE.
REQ-021 In IDLE with line_miss=1, SHALL latch miss_addr, victim_pa and entry_replace_sel, clear the word index, and enter WB_RD if replace_dirty=1, else RF_BUS.
REQ-022 In IDLE with line_miss=0, force_sync=1 and replace_dirty=1, SHALL latch the same fields and enter WB_RD with refill suppressed; line_miss has priority over force_sync.
REQ-023 In WB_RD, SHALL drive cache_addr={sel,idx} with cache_we=0 and go to WB_LD.
REQ-024 In WB_LD, SHALL capture cache_rdata into the write data register and go to WB_BUS.
REQ-025 In WB_BUS, SHALL assert bus_req=1 and bus_we=1, with bus_addr={victim_pa[31:OFS], idx, 2'b00}.
REQ-026 On bus_ack in WB_BUS, SHALL increment idx; at idx=LINE_WORDS-1 go to WB_DONE, else return to WB_RD.
REQ-027 In WB_DONE, SHALL pulse writeback_complete for one cycle, then go to RF_BUS (idx=0) if refill is pending, else IDLE.
REQ-028 In RF_BUS, SHALL assert bus_req=1 and bus_we=0, with bus_addr={miss_addr[31:OFS], idx, 2'b00}.
REQ-029 On bus_ack in RF_BUS, SHALL drive cache_we=1, cache_addr={sel,idx} and cache_wdata=bus_rdata in the same cycle; at the last word go to RF_DONE.
REQ-030 In RF_DONE, SHALL pulse line_refill for one cycle with refill_pa={miss_addr[31:OFS], OFS'b0}, then go to IDLE.
REQ-031 SHALL hold bus_addr, bus_we and bus_wdata stable while bus_req=1 and bus_ack=0.
REQ-032 SHALL deassert bus_req in the cycle after the accepting ack.
REQ-033 SHALL ignore bus_ack when bus_req=0.
REQ-034 SHALL ignore line_miss, force_sync and entry_replace_sel outside IDLE; latched values govern the whole transaction.
REQ-035 SHALL wrap the word index naturally at LINE_WORDS; no extra words are transferred.
REQ-036 SHALL keep cache_we=0 in every state except an acked RF_BUS cycle.

Reset
REQ-037 On rst=1, SHALL enter IDLE and clear idx.
REQ-038 On rst=1, SHALL drive bus_req, cache_we, line_refill, writeback_complete and busy to 0, and refill_pa to 0.
REQ-039 Reset mid-transaction SHALL abort with no line_refill or writeback_complete pulse.
REQ-040 rst SHALL take priority over bus_ack in the same cycle.

Verification
REQ-041 Clean miss: miss_addr=0x00001234, sel=5, replace_dirty=0, ack every cycle -> reads 0x1220..0x123C, cache_addr 40..47 written, line_refill at cycle 10 with refill_pa=0x00001220.
REQ-042 Dirty miss: victim_pa=0x00008000, sel=2 -> cache reads 16..23, bus writes 0x8000..0x801C, one writeback_complete pulse, then refill as in REQ-041.
REQ-043 force_sync only: replace_dirty=1, sel=7 -> 8 writebacks, writeback_complete pulses, no line_refill, back to IDLE.
REQ-044 Bus stall: ack held low 5 cycles on word 3 -> bus_addr, bus_we and bus_wdata unchanged throughout; transaction completes correctly.
REQ-045 Reset on word 4 of refill -> next cycle bus_req=0, busy=0, no line_refill pulse.
REQ-046 Simultaneous line_miss and force_sync in IDLE -> miss serviced and line_refill pulses.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: optional dirty-victim writeback, then a word-by-word line refill.
// Moves data between the single-port cache data RAM and a word bus with a req/ack handshake.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a line miss or a forced sync
// WB_RD     | victim word address presented to the cache RAM
// WB_LD     | cache read data captured into the bus write data register
// WB_BUS    | victim word write on the bus, waiting for ack
// WB_DONE   | writeback_complete pulse; then refill or back to IDLE
// RF_BUS    | refill word read on the bus; the acked word goes into the cache
// RF_DONE   | line_refill pulse with the line-aligned refill address
module cache_refill_ctrl #(
   parameter  int LINE_WORDS = 8,
   parameter  int SEL_WIDTH  = 3,
   localparam int WIDX       = $clog2(LINE_WORDS),
   localparam int OFS        = WIDX + 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      line_miss,
   input  logic                      replace_dirty,
   input  logic                      force_sync,
   input  logic [31:0]               miss_addr,
   input  logic [31:0]               victim_pa,
   input  logic [SEL_WIDTH-1:0]      entry_replace_sel,
   output logic [31:0]               refill_pa,
   output logic                      line_refill,
   output logic                      writeback_complete,
   output logic                      busy,
   output logic [SEL_WIDTH+WIDX-1:0] cache_addr,
   output logic                      cache_we,
   output logic [31:0]               cache_wdata,
   input  logic [31:0]               cache_rdata,
   output logic                      bus_req,
   output logic                      bus_we,
   output logic [31:0]               bus_addr,
   output logic [31:0]               bus_wdata,
   input  logic [31:0]               bus_rdata,
   input  logic                      bus_ack
);

   typedef enum logic [2:0] {
      S_IDLE, S_WB_RD, S_WB_LD, S_WB_BUS, S_WB_DONE, S_RF_BUS, S_RF_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [WIDX-1:0]       r_idx;
   logic [31:0]           r_miss_addr;
   logic [31:0]           r_victim_pa;
   logic [SEL_WIDTH-1:0]  r_sel;
   logic                  r_refill_pend;
   logic [31:0]           r_wdata;
   logic                  w_last;
   logic                  w_start;

   assign w_last  = (r_idx == WIDX'(LINE_WORDS - 1));
   assign w_start = line_miss | (force_sync & replace_dirty);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (line_miss) begin
               w_next = replace_dirty ? S_WB_RD : S_RF_BUS;
            end else if (force_sync && replace_dirty) begin
               w_next = S_WB_RD;
            end
         end
         S_WB_RD:   w_next = S_WB_LD;
         S_WB_LD:   w_next = S_WB_BUS;
         S_WB_BUS: begin
            if (bus_ack) begin
               w_next = w_last ? S_WB_DONE : S_WB_RD;
            end
         end
         S_WB_DONE: w_next = r_refill_pend ? S_RF_BUS : S_IDLE;
         S_RF_BUS: begin
            if (bus_ack && w_last) begin
               w_next = S_RF_DONE;
            end
         end
         S_RF_DONE: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Transaction fields are latched only in IDLE and govern the whole transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx         <= '0;
         r_miss_addr   <= '0;
         r_victim_pa   <= '0;
         r_sel         <= '0;
         r_refill_pend <= 1'b0;
         r_wdata       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_miss_addr   <= miss_addr;
                  r_victim_pa   <= victim_pa;
                  r_sel         <= entry_replace_sel;
                  r_refill_pend <= line_miss;
                  r_idx         <= '0;
               end
            end
            S_WB_LD: r_wdata <= cache_rdata;
            S_WB_BUS: begin
               if (bus_ack) begin
                  r_idx <= r_idx + WIDX'(1);
               end
            end
            S_WB_DONE: r_idx <= '0;
            S_RF_BUS: begin
               if (bus_ack) begin
                  r_idx <= r_idx + WIDX'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Control outputs are gated by rst so a reset cycle never issues or acknowledges anything.
   always_comb begin
      bus_req            = 1'b0;
      bus_we             = 1'b0;
      bus_addr           = {r_victim_pa[31:OFS], r_idx, 2'b00};
      bus_wdata          = r_wdata;
      cache_addr         = {r_sel, r_idx};
      cache_we           = 1'b0;
      cache_wdata        = bus_rdata;
      line_refill        = 1'b0;
      writeback_complete = 1'b0;
      refill_pa          = '0;
      busy               = (r_state != S_IDLE) && !rst;
      case (r_state)
         S_WB_BUS: begin
            bus_req = !rst;
            bus_we  = 1'b1;
         end
         S_WB_DONE: writeback_complete = !rst;
         S_RF_BUS: begin
            bus_req  = !rst;
            bus_addr = {r_miss_addr[31:OFS], r_idx, 2'b00};
            cache_we = bus_ack && !rst;
         end
         S_RF_DONE: begin
            line_refill = !rst;
            if (!rst) begin
               refill_pa = {r_miss_addr[31:OFS], {OFS{1'b0}}};
            end
         end
         default: ;
      endcase
   end

endmodule
